// File: rtl/dc_window_buffer.sv
// Sliding FH x FW window generator over a raster pixel stream using FH-1 line buffers.
// Emits one valid-padded window per producing accept with a single-entry output register.
module dc_window_buffer #(
  parameter int unsigned D            = 2,
  parameter int unsigned FH           = 3,
  parameter int unsigned FW           = 3,
  parameter int unsigned IMG_W        = 4,
  parameter int unsigned IMG_H        = 4,
  parameter int unsigned PINDEX_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [D-1:0]            in_pixel,
  input  logic [PINDEX_WIDTH-1:0] in_pindex,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FH*FW*D-1:0]      data_out,
  output logic [PINDEX_WIDTH-1:0] pindex_out,
  output logic                    frame_done
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned WIN_W = FH * FW * D;
  localparam int unsigned LB_N  = FH - 1;

  typedef enum logic {ST_FILL, ST_EMIT} state_t;

  state_t             state;
  state_t             state_next;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               accept_c;
  logic               col_last_c;
  logic               row_last_c;
  logic               produce_c;
  logic               frame_end_c;
  logic [D-1:0]       line_buf   [LB_N][IMG_W];
  logic [D-1:0]       new_col_c  [FH];
  logic [D-1:0]       win        [FH][FW];
  logic [D-1:0]       win_next_c [FH][FW];
  logic [WIN_W-1:0]   win_flat_c;

  // Ready whenever the output slot is empty or being drained this cycle
  assign in_ready   = !out_valid || out_ready;
  assign accept_c   = in_valid && in_ready;
  assign col_last_c = (col == COL_W'(IMG_W - 1));
  assign row_last_c = (row == ROW_W'(IMG_H - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FILL;
    else     state <= state_next;
  end

  // FSM next state: FILL until FH-1 rows are buffered, EMIT until the frame wraps
  always_comb begin
    state_next = state;
    if (accept_c && col_last_c) begin
      case (state)
        ST_FILL: if (row == ROW_W'(FH - 2)) state_next = ST_EMIT;
        ST_EMIT: if (row_last_c)            state_next = ST_FILL;
        default: state_next = ST_FILL;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    produce_c   = 1'b0;
    frame_end_c = 1'b0;
    if (accept_c) begin
      produce_c   = (state == ST_EMIT) && (col >= COL_W'(FW - 1));
      frame_end_c = col_last_c && row_last_c;
    end
  end

  // Incoming column and shifted window; row 0 is the oldest line
  always_comb begin
    for (int r = 0; r < int'(LB_N); r++) new_col_c[r] = line_buf[r][col];
    new_col_c[FH-1] = in_pixel;
    for (int r = 0; r < int'(FH); r++) begin
      for (int c = 0; c < int'(FW) - 1; c++) win_next_c[r][c] = win[r][c+1];
      win_next_c[r][FW-1] = new_col_c[r];
    end
    win_flat_c = '0;
    for (int r = 0; r < int'(FH); r++) begin
      for (int c = 0; c < int'(FW); c++) win_flat_c[(r*int'(FW)+c)*int'(D) +: D] = win_next_c[r][c];
    end
  end

  // Line buffers and window storage; FILL rows overwrite stale contents before use
  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int r = 0; r < int'(LB_N) - 1; r++) line_buf[r][col] <= line_buf[r+1][col];
      line_buf[LB_N-1][col] <= in_pixel;
      for (int r = 0; r < int'(FH); r++) begin
        for (int c = 0; c < int'(FW); c++) win[r][c] <= win_next_c[r][c];
      end
    end
  end

  // Position counters, output register and frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      pindex_out <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end_c;
      if (accept_c) begin
        if (col_last_c) begin
          col <= '0;
          row <= row_last_c ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (produce_c) begin
        out_valid  <= 1'b1;
        data_out   <= win_flat_c;
        pindex_out <= in_pindex;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dc_window_buffer.sv
// Directed bench for dc_window_buffer (D=2, 3x3 window, 4x4 frame).
// Scoreboard compares every consumed window against a pixel-pattern model.
module tb_dc_window_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_pixel;
  logic [1:0]  in_pindex;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] data_out;
  logic [1:0]  pindex_out;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;

  logic [17:0] q_data[$];
  logic [1:0]  q_pid[$];
  logic [17:0] e_data[$];
  logic [1:0]  e_pid[$];

  dc_window_buffer #(
    .D(2), .FH(3), .FW(3), .IMG_W(4), .IMG_H(4), .PINDEX_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_pindex(in_pindex), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .pindex_out(pindex_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mode 0 is the k mod 4 pattern; mode 1 varies rows so row order matters
  function automatic logic [1:0] pix(input int mode, input int k);
    return (mode == 0) ? 2'(k % 4) : 2'((k * 3 + k / 4) % 4);
  endfunction

  function automatic logic [1:0] pid(input int mode, input int k);
    return (mode == 0) ? 2'(k % 4) : 2'((k + 1) % 4);
  endfunction

  function automatic logic [17:0] exp_win(input int mode, input int kbr);
    logic [17:0] w;
    int r0;
    int c0;
    w  = '0;
    r0 = kbr / 4 - 2;
    c0 = kbr % 4 - 2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*2 +: 2] = pix(mode, (r0 + r) * 4 + c0 + c);
    return w;
  endfunction

  task automatic expect_frame(input int mode);
    int kbr[4];
    kbr = '{10, 11, 14, 15};
    for (int i = 0; i < 4; i++) begin
      e_data.push_back(exp_win(mode, kbr[i]));
      e_pid.push_back(pid(mode, kbr[i]));
    end
  endtask

  task automatic clear_board();
    q_data.delete(); q_pid.delete(); e_data.delete(); e_pid.delete();
    fd_count = 0;
  endtask

  // Record each window on the cycle it is consumed
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      q_data.push_back(data_out);
      q_pid.push_back(pindex_out);
    end
    if (frame_done) fd_count++;
  end

  // Offer one pixel from a negedge and return at the negedge after it is accepted
  task automatic send(input int mode, input int k);
    int budget;
    budget    = 0;
    in_valid  = 1'b1;
    in_pixel  = pix(mode, k);
    in_pindex = pid(mode, k);
    #1;
    while (!in_ready && budget < 50) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic stream_frame(input int mode, input int stall_k, input bit gaps);
    logic [17:0] held;
    logic [1:0]  held_p;
    for (int k = 0; k < 16; k++) begin
      if (k == stall_k) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = pix(mode, k);
        in_pindex = pid(mode, k);
        held      = data_out;
        held_p    = pindex_out;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk); #1;
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(data_out), 32'(held));
          check("stall_pindex", 32'(pindex_out), 32'(held_p));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
      send(mode, k);
      if (k == 10) begin
        check("win10_valid", 32'(out_valid), 32'd1);
        check("win10_data", 32'(data_out), 32'(exp_win(mode, 10)));
        if (mode == 0) begin
          check("first_win_const", 32'(data_out), 32'h24924);
          check("first_pindex", 32'(pindex_out), 32'd2);
        end
      end
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_board(input string tag, input int frames);
    check({tag, "_count"}, 32'(q_data.size()), 32'(e_data.size()));
    check({tag, "_frame_done"}, 32'(fd_count), 32'(frames));
    for (int i = 0; i < e_data.size() && i < q_data.size(); i++) begin
      check($sformatf("%s_win%0d", tag, i), 32'(q_data[i]), 32'(e_data[i]));
      check($sformatf("%s_pidx%0d", tag, i), 32'(q_pid[i]), 32'(e_pid[i]));
    end
    clear_board();
  endtask

  initial begin
    int aborts[2];
    aborts    = '{7, 10};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    in_pindex = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_pindex", 32'(pindex_out), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_board();

    // Single frame, continuous stream
    expect_frame(0);
    stream_frame(0, -1, 1'b0);
    compare_board("single", 1);

    // Downstream stall right after the first window
    expect_frame(0);
    stream_frame(0, 11, 1'b0);
    compare_board("stall", 1);

    // Back-to-back frames, including a pattern change across the frame boundary
    expect_frame(0); expect_frame(0);
    stream_frame(0, -1, 1'b0); stream_frame(0, -1, 1'b0);
    compare_board("b2b", 2);
    expect_frame(1); expect_frame(0);
    stream_frame(1, -1, 1'b0); stream_frame(0, -1, 1'b0);
    compare_board("b2b_mix", 2);

    // Reset mid-frame abandons the partial frame
    for (int a = 0; a < 2; a++) begin
      for (int k = 0; k <= aborts[a]; k++) send(0, k);
      check($sformatf("pre_rst_valid%0d", a), 32'(out_valid), 32'(aborts[a] >= 10));
      rst = 1'b1;
      #1;
      check($sformatf("mid_rst_valid%0d", a), 32'(out_valid), 32'd0);
      check($sformatf("mid_rst_ready%0d", a), 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      clear_board();
      expect_frame(0);
      stream_frame(0, -1, 1'b0);
      compare_board($sformatf("after_rst%0d", a), 1);
    end

    // Gappy input valid
    expect_frame(0);
    stream_frame(0, -1, 1'b1);
    compare_board("gaps0", 1);
    expect_frame(1);
    stream_frame(1, -1, 1'b1);
    compare_board("gaps1", 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
